// File: rtl/mips_lite_pkg.sv
// Shared definitions for the MIPS-lite front end: fetch FSM encoding,
// reset vector and instruction field positions.
package mips_lite_pkg;

  localparam logic [1:0] ST_FETCH = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_ERR   = 2'd2;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  localparam int OP_MSB = 31;
  localparam int OP_LSB = 26;
  localparam int JIMM_W = 26;

  // Instruction addresses are word aligned; the two low bits are always zero.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/pc_next_logic.sv
// Combinational next-PC selection for the fetch stage: jalr, jump,
// conditional branch (beq-style or bge-style) or fall-through.
module pc_next_logic
  import mips_lite_pkg::*;
(
  input  logic [31:0] i_pc,
  input  logic [31:0] i_instr,
  input  logic        i_branch,
  input  logic        i_bge,
  input  logic        i_jump,
  input  logic        i_jalr,
  input  logic        i_zero,
  input  logic        i_ge,
  input  logic [31:0] i_signimm,
  input  logic [31:0] i_rs_val,
  output logic [31:0] o_pc_next,
  output logic [31:0] o_pcplus4
);

  logic        w_branch_taken;
  logic [31:0] w_branch_target;
  logic [31:0] w_jump_target;
  logic        w_unused_bits;

  assign o_pcplus4       = i_pc + 32'd4;
  // bge overrides the plain equality test when both decoder controls are set.
  assign w_branch_taken  = (i_branch & ~i_bge & i_zero) | (i_bge & i_ge);
  assign w_branch_target = o_pcplus4 + {i_signimm[29:0], 2'b00};
  assign w_jump_target   = {o_pcplus4[31:28], i_instr[JIMM_W-1:0], 2'b00};

  assign w_unused_bits = &{1'b0, i_instr[OP_MSB:OP_LSB], i_signimm[31:30], i_rs_val[1:0]};

  // NOTE: every output of an always_comb gets a default first so no path can infer a latch.
  always_comb begin
    o_pc_next = o_pcplus4;
    if (i_jalr) begin
      o_pc_next = word_align(i_rs_val);
    end else if (i_jump) begin
      o_pc_next = w_jump_target;
    end else if (w_branch_taken) begin
      o_pc_next = w_branch_target;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches over a req/ack memory port,
// holds the word for the decoder and advances on downstream completion.
module fetch_unit
  import mips_lite_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          TIMEOUT  = 16,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic             imem_ack,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      instr,
  output logic             instr_valid,
  input  logic             exec_done,
  input  logic             branch,
  input  logic             bge,
  input  logic             jump,
  input  logic             jalr,
  input  logic             zero,
  input  logic             ge,
  input  logic [31:0]      signimm,
  input  logic [31:0]      rs_val,
  output logic [31:0]      pc,
  output logic [31:0]      pcplus4,
  output logic [CNT_W-1:0] retired,
  output logic             fetch_err
);

  localparam int                WAIT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  logic [1:0]        r_state;
  logic [31:0]       r_pc;
  logic [31:0]       r_instr;
  logic              r_instr_valid;
  logic [CNT_W-1:0]  r_retired;
  logic              r_fetch_err;
  logic [WAIT_W-1:0] r_wait_cnt;

  logic [31:0]       w_pc_next;
  logic [31:0]       w_pcplus4;

  pc_next_logic u_pc_next (
    .i_pc      (r_pc),
    .i_instr   (r_instr),
    .i_branch  (branch),
    .i_bge     (bge),
    .i_jump    (jump),
    .i_jalr    (jalr),
    .i_zero    (zero),
    .i_ge      (ge),
    .i_signimm (signimm),
    .i_rs_val  (rs_val),
    .o_pc_next (w_pc_next),
    .o_pcplus4 (w_pcplus4)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_FETCH;
      r_pc          <= RESET_PC;
      r_instr       <= '0;
      r_instr_valid <= 1'b0;
      r_retired     <= '0;
      r_fetch_err   <= 1'b0;
      r_wait_cnt    <= '0;
    end else begin
      case (r_state)
        ST_FETCH: begin
          // An ack in the final allowed cycle still beats the timeout.
          if (imem_ack) begin
            r_instr       <= imem_rdata;
            r_instr_valid <= 1'b1;
            r_wait_cnt    <= '0;
            r_state       <= ST_ISSUE;
          end else if (r_wait_cnt == WAIT_LAST) begin
            r_fetch_err <= 1'b1;
            r_wait_cnt  <= '0;
            r_state     <= ST_ERR;
          end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
        end
        ST_ISSUE: begin
          if (exec_done) begin
            r_pc          <= w_pc_next;
            r_retired     <= r_retired + 1'b1;
            r_instr_valid <= 1'b0;
            r_state       <= ST_FETCH;
          end
        end
        ST_ERR: begin
          r_instr_valid <= 1'b0;
        end
        default: begin
          r_instr_valid <= 1'b0;
          r_state       <= ST_ERR;
        end
      endcase
    end
  end

  // The request is gated by reset directly so a reset cycle never issues a fetch.
  assign imem_req    = (r_state == ST_FETCH) & ~reset;
  assign imem_addr   = r_pc;
  assign instr       = r_instr;
  assign instr_valid = r_instr_valid;
  assign pc          = r_pc;
  assign pcplus4     = w_pcplus4;
  assign retired     = r_retired;
  assign fetch_err   = r_fetch_err;

endmodule
